multi_stream_reader: RTL and testbench

//  Parametrised N-channel AXI read streamer: per channel, accepts (byte addr, element count) commands, issues 64B

---
 rtl/multi_stream_reader_pkg.sv | 11 +
 rtl/stream_line_slot.sv | 142 ++++++++++++++
 rtl/multi_stream_reader.sv | 109 ++++++++++
 tb/tb_multi_stream_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_stream_reader_pkg.sv
// multi_stream_reader_pkg: shared line/AXI constants, channel and slot state encodings, line address helper
package multi_stream_reader_pkg;
  localparam int LINE_W = 512;
  localparam int LINE_B = 64;
  localparam logic [2:0] AXI_SIZE_64B = 3'b110;
  typedef enum logic [1:0] {CH_IDLE, CH_ISSUE, CH_DRAIN} ch_state_t;
  typedef enum logic [1:0] {SL_EMPTY, SL_PEND, SL_FULL} slot_state_t;
  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return a & ~64'(LINE_B - 1);
  endfunction
endpackage

// File: rtl/stream_line_slot.sv
// stream_line_slot: one channel of the reader - command FSM, remaining-count, two ping-pong line slots, unpack mux
//   cmd_valid/cmd_ready/cmd_addr/cmd_count : command in (accepted while idle)
//   out_valid/out_ready/out_data/out_last  : element stream out
//   busy                                   : channel not idle
//   ar_req/ar_addr/ar_grant                : line read request to the arbiter, grant = AR handshake for us
//   r_fill/r_data/fill_ok                  : returned beat for this channel, fill_ok = a slot is waiting for it
module stream_line_slot
  import multi_stream_reader_pkg::*;
#(
  parameter int ELEM_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [63:0]         cmd_addr,
  input  logic [CNT_W-1:0]    cmd_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                ar_req,
  output logic [63:0]         ar_addr,
  input  logic                ar_grant,
  input  logic                r_fill,
  input  logic [LINE_W-1:0]   r_data,
  output logic                fill_ok
);
  localparam int EPL = LINE_W / ELEM_W;
  localparam int IW  = $clog2(EPL);
  localparam int EB  = $clog2(ELEM_W / 8);
  localparam int SH  = $clog2(ELEM_W);
  localparam int OW  = $clog2(LINE_W);
  ch_state_t          st;
  logic [CNT_W-1:0]   rem;
  logic [63:0]        addr;
  logic [IW-1:0]      s0;
  logic               first;
  logic               rdy;
  slot_state_t        sst [2];
  logic [LINE_W-1:0]  dat [2];
  logic [IW-1:0]      ss [2];
  logic [IW:0]        sn [2];
  logic               sl [2];
  logic               iss, fil, hd;
  logic [IW:0]        k;
  logic [IW-1:0]      s_now, idx;
  logic [CNT_W-1:0]   avail;
  logic [IW:0]        n_now;
  logic [OW-1:0]      off;
  logic               k_end, pop, fin;
  always_comb begin
    s_now     = first ? s0 : '0;
    avail     = CNT_W'(EPL) - CNT_W'(s_now);
    n_now     = (rem < avail) ? rem[IW:0] : avail[IW:0];
    fin       = rem == CNT_W'(n_now);
    ar_req    = st == CH_ISSUE && sst[iss] == SL_EMPTY;
    ar_addr   = addr;
    fill_ok   = sst[fil] == SL_PEND;
    out_valid = sst[hd] == SL_FULL;
    idx       = ss[hd] + k[IW-1:0];
    off       = OW'(idx) << SH;
    out_data  = out_valid ? dat[hd][off +: ELEM_W] : '0;
    k_end     = k == sn[hd] - 1'b1;
    out_last  = out_valid & sl[hd] & k_end;
    pop       = out_valid & out_ready;
    busy      = st != CH_IDLE;
    cmd_ready = rdy;
  end
  // line data has no reset; out_data is gated by out_valid instead
  always_ff @(posedge clk)
    if (r_fill && fill_ok) dat[fil] <= r_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= CH_IDLE;
      rem <= '0;
      addr <= '0;
      s0 <= '0;
      first <= 1'b0;
      rdy <= 1'b0;
      iss <= 1'b0;
      fil <= 1'b0;
      hd <= 1'b0;
      k <= '0;
      sst[0] <= SL_EMPTY;
      sst[1] <= SL_EMPTY;
      ss[0] <= '0;
      ss[1] <= '0;
      sn[0] <= '0;
      sn[1] <= '0;
      sl[0] <= 1'b0;
      sl[1] <= 1'b0;
    end else begin
      case (st)
        CH_IDLE:
          if (cmd_valid && rdy) begin
            if (cmd_count != '0) begin
              st <= CH_ISSUE;
              rdy <= 1'b0;
            end
            rem <= cmd_count;
            addr <= line_addr(cmd_addr);
            s0 <= cmd_addr[5:EB];
            first <= 1'b1;
          end else rdy <= 1'b1;
        CH_ISSUE:
          if (ar_grant) begin
            rem <= rem - CNT_W'(n_now);
            addr <= addr + 64'(LINE_B);
            first <= 1'b0;
            if (fin) st <= CH_DRAIN;
          end
        CH_DRAIN:
          if (pop && out_last) begin
            st <= CH_IDLE;
            rdy <= 1'b1;
          end
        default: st <= CH_IDLE;
      endcase
      // issue, fill and pop always touch different slots (EMPTY / PEND / FULL)
      if (ar_grant && ar_req) begin
        sst[iss] <= SL_PEND;
        ss[iss] <= s_now;
        sn[iss] <= n_now;
        sl[iss] <= fin;
        iss <= ~iss;
      end
      if (r_fill && fill_ok) begin
        sst[fil] <= SL_FULL;
        fil <= ~fil;
      end
      if (pop) begin
        if (k_end) begin
          sst[hd] <= SL_EMPTY;
          hd <= ~hd;
          k <= '0;
        end else k <= k + 1'b1;
      end
    end
endmodule

// File: rtl/multi_stream_reader.sv
// multi_stream_reader: N-channel AXI line-read streamer unpacking 512-bit beats into ELEM_W-bit elements
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_valid/ready/addr/count    : per-channel commands (byte address, element count)
//   out_valid/ready/data/last     : per-channel element streams
//   busy                          : per-channel not idle
//   err                           : sticky error (bad rresp, unknown rid, beat with nothing outstanding)
//   ar*_m / r*_m                  : AXI read address / data channels, single-beat 64B reads
module multi_stream_reader
  import multi_stream_reader_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int ELEM_W  = 64,
  parameter int ID_BASE = 0,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         cmd_valid,
  output logic [N_CH-1:0]         cmd_ready,
  input  logic [N_CH*64-1:0]      cmd_addr,
  input  logic [N_CH*CNT_W-1:0]   cmd_count,
  output logic [N_CH-1:0]         out_valid,
  input  logic [N_CH-1:0]         out_ready,
  output logic [N_CH*ELEM_W-1:0]  out_data,
  output logic [N_CH-1:0]         out_last,
  output logic [N_CH-1:0]         busy,
  output logic                    err,
  output logic [15:0]             arid_m,
  output logic [63:0]             araddr_m,
  output logic [7:0]              arlen_m,
  output logic [2:0]              arsize_m,
  output logic                    arvalid_m,
  input  logic                    arready_m,
  input  logic [15:0]             rid_m,
  input  logic [LINE_W-1:0]       rdata_m,
  input  logic [1:0]              rresp_m,
  input  logic                    rlast_m,
  input  logic                    rvalid_m,
  output logic                    rready_m
);
  localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [N_CH-1:0] req, grant, fill, fill_ok;
  logic [63:0]     ch_addr [N_CH];
  logic [PW-1:0]   ptr, win, sel, lock_ch, jj;
  logic            locked;
  logic [15:0]     rel;
  int              j;
  logic            unused_rlast;
  assign unused_rlast = rlast_m;
  assign rready_m = 1'b1;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    stream_line_slot #(.ELEM_W(ELEM_W), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid[c]),
      .cmd_ready (cmd_ready[c]),
      .cmd_addr  (cmd_addr[c*64 +: 64]),
      .cmd_count (cmd_count[c*CNT_W +: CNT_W]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_data  (out_data[c*ELEM_W +: ELEM_W]),
      .out_last  (out_last[c]),
      .busy      (busy[c]),
      .ar_req    (req[c]),
      .ar_addr   (ch_addr[c]),
      .ar_grant  (grant[c]),
      .r_fill    (fill[c]),
      .r_data    (rdata_m),
      .fill_ok   (fill_ok[c])
    );
    assign grant[c] = arvalid_m & arready_m & (sel == PW'(c));
    assign fill[c]  = rvalid_m & (rel == 16'(c));
  end
  // round-robin: scan from ptr upward; the lowest offset that requests wins
  always_comb begin
    win = ptr;
    j = 0;
    jj = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      jj = PW'(j);
      if (req[jj]) win = jj;
    end
  end
  // a stalled AR stays locked on its channel so the address/id cannot change before arready
  always_comb begin
    sel       = locked ? lock_ch : win;
    arvalid_m = locked | (|req);
    araddr_m  = arvalid_m ? ch_addr[sel] : '0;
    arid_m    = arvalid_m ? 16'(ID_BASE) + 16'(sel) : '0;
    arsize_m  = arvalid_m ? AXI_SIZE_64B : '0;
    arlen_m   = '0;
    rel       = rid_m - 16'(ID_BASE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      locked <= 1'b0;
      lock_ch <= '0;
      err <= 1'b0;
    end else begin
      locked <= arvalid_m & ~arready_m;
      lock_ch <= sel;
      if (arvalid_m && arready_m) ptr <= (int'(sel) == N_CH - 1) ? '0 : sel + 1'b1;
      // out-of-range rid never produces a fill strobe, so it is caught by the no-fill term
      if (rvalid_m && (rresp_m != 2'b00 || !(|(fill & fill_ok)))) err <= 1'b1;
    end
endmodule

// File: tb/tb_multi_stream_reader.sv
// tb_multi_stream_reader: directed bench with AXI slave model returning lane data = element byte address
module tb_multi_stream_reader;
  localparam int N_CH = 4, ELEM_W = 64, ID_BASE = 0, CNT_W = 32;
  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        cmd_valid, cmd_ready, out_valid, out_ready, out_last, busy;
  logic [N_CH*64-1:0]     cmd_addr;
  logic [N_CH*CNT_W-1:0]  cmd_count;
  logic [N_CH*ELEM_W-1:0] out_data;
  logic                   err, arvalid_m, arready_m, rlast_m, rvalid_m, rready_m;
  logic [15:0]            arid_m, rid_m;
  logic [63:0]            araddr_m;
  logic [7:0]             arlen_m;
  logic [2:0]             arsize_m;
  logic [511:0]           rdata_m;
  logic [1:0]             rresp_m;
  always #5 clk = ~clk;
  multi_stream_reader #(.N_CH(N_CH), .ELEM_W(ELEM_W), .ID_BASE(ID_BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_count(cmd_count), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err), .arid_m(arid_m), .araddr_m(araddr_m),
    .arlen_m(arlen_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
    .rready_m(rready_m));
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  logic [79:0] rq[$];
  logic [63:0] ar_addr_log[$];
  logic [15:0] ar_id_log[$];
  logic [64:0] expq [N_CH][$];
  int          pops [N_CH];
  int          outst [N_CH];
  int          max_out = 0;
  bit          ar_rand = 0, bad_id_req = 0, bad_resp_req = 0;
  function automatic int pending();
    int s = 0;
    for (int c = 0; c < N_CH; c++) s += expq[c].size();
    return s;
  endfunction
  task automatic clear_model();
    for (int c = 0; c < N_CH; c++) begin
      expq[c].delete();
      pops[c] = 0;
      outst[c] = 0;
    end
    rq.delete();
    ar_addr_log.delete();
    ar_id_log.delete();
    max_out = 0;
  endtask
  // AXI slave: drives at negedge, samples handshakes 1 time unit before posedge
  initial begin : slave
    logic [79:0] e;
    logic [80:0] prev_ar;
    bit stall_prev;
    stall_prev = 0;
    prev_ar = '0;
    arready_m = 1'b1;
    rvalid_m = 1'b0;
    rid_m = '0;
    rdata_m = '0;
    rresp_m = '0;
    rlast_m = 1'b0;
    forever begin
      @(negedge clk);
      arready_m = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rvalid_m = 1'b0;
      rresp_m = 2'b00;
      rlast_m = 1'b0;
      if (!rst && bad_id_req) begin
        rvalid_m = 1'b1;
        rlast_m = 1'b1;
        rid_m = 16'(ID_BASE + N_CH);
        rdata_m = '0;
        bad_id_req = 0;
      end else if (!rst && rq.size() > 0 && $urandom_range(0, 3) != 0) begin
        e = rq.pop_front();
        rvalid_m = 1'b1;
        rlast_m = 1'b1;
        rid_m = e[79:64];
        for (int i = 0; i < 8; i++) rdata_m[i*64 +: 64] = e[63:0] + 64'(8 * i);
        rresp_m = bad_resp_req ? 2'b10 : 2'b00;
        bad_resp_req = 0;
      end
      #4;
      if (rst) begin
        rq.delete();
        for (int c = 0; c < N_CH; c++) outst[c] = 0;
        stall_prev = 0;
      end else begin
        if (stall_prev) check("ar_stable", {arvalid_m, arid_m, araddr_m}, prev_ar);
        stall_prev = arvalid_m && !arready_m;
        prev_ar = {arvalid_m, arid_m, araddr_m};
        if (arvalid_m && arready_m) begin
          rq.push_back({arid_m, araddr_m});
          ar_addr_log.push_back(araddr_m);
          ar_id_log.push_back(arid_m);
          if (int'(arid_m) - ID_BASE < N_CH) begin
            outst[int'(arid_m) - ID_BASE]++;
            if (outst[int'(arid_m) - ID_BASE] > max_out) max_out = outst[int'(arid_m) - ID_BASE];
          end
        end
        if (rvalid_m && int'(rid_m) - ID_BASE < N_CH) outst[int'(rid_m) - ID_BASE]--;
      end
    end
  end
  // element consumer/scoreboard
  initial begin : mon
    logic [64:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst)
        for (int c = 0; c < N_CH; c++)
          if (out_valid[c] && out_ready[c]) begin
            pops[c]++;
            if (expq[c].size() == 0) check($sformatf("extra_ch%0d", c), 1, 0);
            else begin
              e = expq[c].pop_front();
              check($sformatf("data_ch%0d", c), out_data[c*64 +: 64], e[63:0]);
              check($sformatf("last_ch%0d", c), out_last[c], e[64]);
            end
          end
    end
  end
  task automatic send(input int c, input logic [63:0] a, input logic [31:0] n);
    for (int j = 0; j < int'(n); j++) expq[c].push_back({j == int'(n) - 1, a + 64'(8 * j)});
    @(negedge clk);
    cmd_valid[c] = 1'b1;
    cmd_addr[c*64 +: 64] = a;
    cmd_count[c*32 +: 32] = n;
    for (int t = 0; t < 200 && !cmd_ready[c]; t++) @(negedge clk);
    check($sformatf("cmd_rdy_ch%0d", c), cmd_ready[c], 1);
    @(negedge clk);
    cmd_valid[c] = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int t = 0;
    while (t < 20000 && (busy != '0 || pending() != 0)) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_left"}, pending(), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = '0;
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin : wd
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    cmd_valid = '0;
    cmd_addr = '0;
    cmd_count = '0;
    out_ready = '1;
    clear_model();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_arvalid", arvalid_m, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_err", err, 0);
    check("rst_rready", rready_m, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("cmd_ready_up", cmd_ready, 4'hF);
    // 1: aligned single line
    send(0, 64'h1000, 8);
    check("t1_arvalid_next", arvalid_m, 1);
    check("t1_busy", busy[0], 1);
    wait_done("t1");
    check("t1_ar_n", ar_addr_log.size(), 1);
    check("t1_ar_addr", ar_addr_log[0], 64'h1000);
    check("t1_pops", pops[0], 8);
    // 2: unaligned start spanning two lines
    clear_model();
    send(1, 64'h1018, 10);
    wait_done("t2");
    check("t2_ar_n", ar_addr_log.size(), 2);
    check("t2_ar0", ar_addr_log[0], 64'h1000);
    check("t2_ar1", ar_addr_log[1], 64'h1040);
    check("t2_id0", ar_id_log[0], 1);
    check("t2_id1", ar_id_log[1], 1);
    check("t2_pops", pops[1], 10);
    // 3: all channels, random arready
    do_reset();
    ar_rand = 1;
    for (int c = 0; c < N_CH; c++) begin
      for (int j = 0; j < 64; j++) expq[c].push_back({j == 63, 64'h10000 * 64'(c + 1) + 64'(8 * j)});
      cmd_addr[c*64 +: 64] = 64'h10000 * 64'(c + 1);
      cmd_count[c*32 +: 32] = 32'd64;
    end
    cmd_valid = '1;
    @(negedge clk);
    cmd_valid = '0;
    wait_done("t3");
    ar_rand = 0;
    for (int i = 0; i < 8; i++) check($sformatf("t3_arid%0d", i), ar_id_log[i], i % 4);
    check("t3_ar_n", ar_addr_log.size(), 32);
    check("t3_max_out_le2", max_out <= 2, 1);
    // 4: consumer stall on ch2
    clear_model();
    out_ready[2] = 1'b0;
    send(2, 64'h2000, 32);
    repeat (200) @(negedge clk);
    check("t4_ar_stalled", ar_addr_log.size(), 2);
    check("t4_valid_held", out_valid[2], 1);
    check("t4_busy", busy[2], 1);
    out_ready[2] = 1'b1;
    wait_done("t4");
    check("t4_ar_n", ar_addr_log.size(), 4);
    check("t4_pops", pops[2], 32);
    // 5: error reporting
    check("t5_err0", err, 0);
    bad_resp_req = 1;
    send(0, 64'h3000, 8);
    wait_done("t5a");
    check("t5_err_resp", err, 1);
    check("t5_pops", pops[0], 8);
    do_reset();
    check("t5_err_cleared", err, 0);
    @(negedge clk);
    bad_id_req = 1;
    repeat (4) @(negedge clk);
    check("t5_err_rid", err, 1);
    send(1, 64'h4008, 3);
    wait_done("t5b");
    check("t5_err_sticky", err, 1);
    check("t5b_pops", pops[1], 3);
    // 6: zero count and mid-stream reset
    clear_model();
    send(3, 64'h5000, 0);
    repeat (5) @(negedge clk);
    check("t6_no_ar", ar_addr_log.size(), 0);
    check("t6_rdy", cmd_ready[3], 1);
    check("t6_busy", busy[3], 0);
    send(0, 64'h6000, 64);
    repeat (5) @(negedge clk);
    check("t6_busy_mid", busy[0], 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_arvalid", arvalid_m, 0);
    check("t6_rst_rdy", cmd_ready, 0);
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(0, 64'h7000, 4);
    wait_done("t6_after");
    check("t6_after_pops", pops[0], 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
